// File: rtl/minmax_datapath.sv
// Min/max tracking datapath: two-stage sample pipe, running min/max registers,
// forwarded comparator flags for the controller, saturating sample counter and range.
module minmax_datapath #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 reg_clr,
  input  logic                 reg_ld,
  input  logic                 max_clr,
  input  logic                 max_ld,
  input  logic                 min_clr,
  input  logic                 min_ld,
  output logic                 A_lt_B,
  output logic                 C_gt_D,
  output logic [WIDTH-1:0]     min_out,
  output logic [WIDTH-1:0]     max_out,
  output logic [WIDTH-1:0]     range_out,
  output logic [CNT_WIDTH-1:0] sample_cnt,
  output logic                 stats_valid
);

  logic [WIDTH-1:0]     r_in;
  logic [WIDTH-1:0]     r_cand;
  logic                 r_in_vld;
  logic                 r_cand_vld;
  logic [WIDTH-1:0]     r_min;
  logic [WIDTH-1:0]     r_max;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_stats_vld;

  logic                 w_min_commit;
  logic                 w_max_commit;
  logic [WIDTH-1:0]     w_eff_min;
  logic [WIDTH-1:0]     w_eff_max;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in       <= '0;
      r_cand     <= '0;
      r_in_vld   <= 1'b0;
      r_cand_vld <= 1'b0;
      r_cnt      <= '0;
    end else if (reg_clr) begin
      r_in       <= '0;
      r_cand     <= '0;
      r_in_vld   <= 1'b0;
      r_cand_vld <= 1'b0;
      r_cnt      <= '0;
    end else if (reg_ld) begin
      r_in       <= data_in;
      r_in_vld   <= 1'b1;
      r_cand     <= r_in;
      r_cand_vld <= r_in_vld;
      if (r_cnt != '1)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_min_commit = min_ld & r_cand_vld;
  assign w_max_commit = max_ld & r_cand_vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_min       <= '1;
      r_max       <= '0;
      r_stats_vld <= 1'b0;
    end else begin
      if (min_clr)
        r_min <= '1;
      else if (w_min_commit)
        r_min <= r_cand;
      if (max_clr)
        r_max <= '0;
      else if (w_max_commit)
        r_max <= r_cand;
      // Any clear invalidates the stats, even when the other side loads.
      if (min_clr | max_clr)
        r_stats_vld <= 1'b0;
      else if (w_min_commit | w_max_commit)
        r_stats_vld <= 1'b1;
    end
  end

  // Compare against the value the registers take at the next edge, so a
  // back-to-back commit and compare see consistent bounds.
  always_comb begin
    w_eff_min = r_min;
    w_eff_max = r_max;
    if (min_clr)
      w_eff_min = '1;
    else if (w_min_commit)
      w_eff_min = r_cand;
    if (max_clr)
      w_eff_max = '0;
    else if (w_max_commit)
      w_eff_max = r_cand;
  end

  assign A_lt_B      = r_in_vld & (r_in < w_eff_min);
  assign C_gt_D      = r_in_vld & (r_in > w_eff_max);
  assign min_out     = r_min;
  assign max_out     = r_max;
  assign range_out   = (r_stats_vld && (r_max >= r_min)) ? (r_max - r_min) : '0;
  assign sample_cnt  = r_cnt;
  assign stats_valid = r_stats_vld;

endmodule

// File: tb/tb_minmax_datapath.sv
// Directed testbench for minmax_datapath: reset, first sample, forwarding,
// clear/load priority, counter saturation and asynchronous reset.
module tb_minmax_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_in;
  logic        reg_clr, reg_ld, max_clr, max_ld, min_clr, min_ld;
  logic        A_lt_B, C_gt_D, stats_valid;
  logic [7:0]  min_out, max_out, range_out;
  logic [15:0] sample_cnt;
  logic        A4, C4, sv4;
  logic [7:0]  min4, max4, range4;
  logic [3:0]  cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  minmax_datapath #(.WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .data_in(data_in),
    .reg_clr(reg_clr), .reg_ld(reg_ld), .max_clr(max_clr), .max_ld(max_ld),
    .min_clr(min_clr), .min_ld(min_ld),
    .A_lt_B(A_lt_B), .C_gt_D(C_gt_D), .min_out(min_out), .max_out(max_out),
    .range_out(range_out), .sample_cnt(sample_cnt), .stats_valid(stats_valid)
  );

  minmax_datapath #(.WIDTH(8), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .data_in(data_in),
    .reg_clr(reg_clr), .reg_ld(reg_ld), .max_clr(max_clr), .max_ld(max_ld),
    .min_clr(min_clr), .min_ld(min_ld),
    .A_lt_B(A4), .C_gt_D(C4), .min_out(min4), .max_out(max4),
    .range_out(range4), .sample_cnt(cnt4), .stats_valid(sv4)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    checks++; if (min_out !== 8'hFF) begin errors++; $display("FAIL rst_min: got %0h exp ff", min_out); end
    checks++; if (max_out !== 8'h00) begin errors++; $display("FAIL rst_max: got %0h exp 0", max_out); end
    checks++; if ({A_lt_B, C_gt_D} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b exp 00", {A_lt_B, C_gt_D}); end
    checks++; if (range_out !== 8'h00) begin errors++; $display("FAIL rst_range: got %0h exp 0", range_out); end
    checks++; if (sample_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0d exp 0", sample_cnt); end
    checks++; if (stats_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", stats_valid); end
    checks++; if (cnt4 !== 4'd0) begin errors++; $display("FAIL rst_cnt4: got %0d exp 0", cnt4); end
    reg_clr = 1'b1; min_clr = 1'b1; max_clr = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    cyc(); cyc();
    checks++; if (min_out !== 8'hFF || max_out !== 8'h00) begin errors++; $display("FAIL s0_minmax: got %0h/%0h exp ff/0", min_out, max_out); end
    checks++; if ({A_lt_B, C_gt_D, stats_valid} !== 3'b000) begin errors++; $display("FAIL s0_flags: got %b exp 000", {A_lt_B, C_gt_D, stats_valid}); end
    reg_clr = 1'b0; min_clr = 1'b0; max_clr = 1'b0;
  endtask

  task automatic test_first_sample();
    reg_ld = 1'b1; data_in = 8'd5;
    cyc();
    checks++; if ({A_lt_B, C_gt_D} !== 2'b11) begin errors++; $display("FAIL first_flags: got %b exp 11", {A_lt_B, C_gt_D}); end
    checks++; if (sample_cnt !== 16'd1) begin errors++; $display("FAIL first_cnt: got %0d exp 1", sample_cnt); end
    data_in = 8'd9;
    cyc();
    min_ld = 1'b1; max_ld = 1'b1; data_in = 8'd7;
    #1;
    checks++; if ({A_lt_B, C_gt_D} !== 2'b01) begin errors++; $display("FAIL in9_flags: got %b exp 01", {A_lt_B, C_gt_D}); end
    cyc();
    checks++; if (min_out !== 8'd5 || max_out !== 8'd5) begin errors++; $display("FAIL first_commit: got %0d/%0d exp 5/5", min_out, max_out); end
    checks++; if (stats_valid !== 1'b1 || range_out !== 8'd0) begin errors++; $display("FAIL first_valid: got %b/%0d exp 1/0", stats_valid, range_out); end
  endtask

  task automatic test_forwarding();
    min_ld = 1'b0; max_ld = 1'b1; data_in = 8'd3;
    #1;
    checks++; if ({A_lt_B, C_gt_D} !== 2'b00) begin errors++; $display("FAIL in7_noflag: got %b exp 00", {A_lt_B, C_gt_D}); end
    cyc();
    checks++; if (max_out !== 8'd9 || range_out !== 8'd4) begin errors++; $display("FAIL max9: got %0d/%0d exp 9/4", max_out, range_out); end
    max_ld = 1'b0; data_in = 8'd4;
    #1;
    checks++; if ({A_lt_B, C_gt_D} !== 2'b10) begin errors++; $display("FAIL in3_flags: got %b exp 10", {A_lt_B, C_gt_D}); end
    cyc();
    min_ld = 1'b1; data_in = 8'd3;
    #1;
    checks++; if ({A_lt_B, C_gt_D} !== 2'b00) begin errors++; $display("FAIL fwd_min: got %b exp 00", {A_lt_B, C_gt_D}); end
    cyc();
    checks++; if (min_out !== 8'd3 || range_out !== 8'd6) begin errors++; $display("FAIL min3: got %0d/%0d exp 3/6", min_out, range_out); end
    checks++; if (sample_cnt !== 16'd6) begin errors++; $display("FAIL cnt6: got %0d exp 6", sample_cnt); end
    min_ld = 1'b0; reg_ld = 1'b0;
    #1;
    checks++; if ({A_lt_B, C_gt_D} !== 2'b00) begin errors++; $display("FAIL equal_min: got %b exp 00", {A_lt_B, C_gt_D}); end
  endtask

  task automatic test_clear_priority();
    reg_clr = 1'b1; reg_ld = 1'b1; data_in = 8'd77;
    cyc();
    reg_clr = 1'b0; reg_ld = 1'b0;
    #1;
    checks++; if (sample_cnt !== 16'd0) begin errors++; $display("FAIL clr_cnt: got %0d exp 0", sample_cnt); end
    checks++; if ({A_lt_B, C_gt_D} !== 2'b00) begin errors++; $display("FAIL clr_invld: got %b exp 00", {A_lt_B, C_gt_D}); end
    min_ld = 1'b1; max_ld = 1'b1;
    cyc();
    min_ld = 1'b0; max_ld = 1'b0;
    checks++; if (min_out !== 8'd3 || max_out !== 8'd9 || stats_valid !== 1'b1) begin errors++; $display("FAIL ld_nocand: got %0d/%0d/%b exp 3/9/1", min_out, max_out, stats_valid); end
    reg_ld = 1'b1; data_in = 8'd1;
    cyc();
    data_in = 8'd2;
    cyc();
    reg_ld = 1'b0; min_ld = 1'b1; max_clr = 1'b1;
    #1;
    checks++; if ({A_lt_B, C_gt_D} !== 2'b01) begin errors++; $display("FAIL clr_fwd: got %b exp 01", {A_lt_B, C_gt_D}); end
    cyc();
    min_ld = 1'b0; max_clr = 1'b0;
    checks++; if (min_out !== 8'd1 || max_out !== 8'd0) begin errors++; $display("FAIL clr_ld_regs: got %0d/%0d exp 1/0", min_out, max_out); end
    checks++; if (stats_valid !== 1'b0 || range_out !== 8'd0) begin errors++; $display("FAIL clr_wins: got %b/%0d exp 0/0", stats_valid, range_out); end
  endtask

  task automatic test_saturation();
    reg_clr = 1'b1;
    cyc();
    reg_clr = 1'b0; reg_ld = 1'b1;
    repeat (15) cyc();
    checks++; if (cnt4 !== 4'd15 || sample_cnt !== 16'd15) begin errors++; $display("FAIL cnt15: got %0d/%0d exp 15/15", cnt4, sample_cnt); end
    repeat (5) cyc();
    checks++; if (cnt4 !== 4'd15) begin errors++; $display("FAIL cnt4_sat: got %0d exp 15", cnt4); end
    checks++; if (sample_cnt !== 16'd20) begin errors++; $display("FAIL cnt20: got %0d exp 20", sample_cnt); end
    reg_ld = 1'b0;
  endtask

  task automatic test_async_reset();
    reg_clr = 1'b1; min_clr = 1'b1; max_clr = 1'b1;
    cyc();
    reg_clr = 1'b0; min_clr = 1'b0; max_clr = 1'b0;
    reg_ld = 1'b1; data_in = 8'd2;
    cyc();
    data_in = 8'd200;
    cyc();
    min_ld = 1'b1; max_ld = 1'b1; data_in = 8'd50;
    cyc();
    min_ld = 1'b0;
    cyc();
    max_ld = 1'b0; reg_ld = 1'b0;
    checks++; if (min_out !== 8'd2 || max_out !== 8'd200 || range_out !== 8'd198) begin errors++; $display("FAIL pre_rst: got %0d/%0d/%0d exp 2/200/198", min_out, max_out, range_out); end
    #2 rst = 1'b0;
    #1;
    checks++; if (min_out !== 8'hFF || max_out !== 8'h00 || range_out !== 8'h00) begin errors++; $display("FAIL async_regs: got %0h/%0h/%0h exp ff/0/0", min_out, max_out, range_out); end
    checks++; if ({A_lt_B, C_gt_D, stats_valid} !== 3'b000 || sample_cnt !== 16'd0) begin errors++; $display("FAIL async_ctl: got %b/%0d exp 000/0", {A_lt_B, C_gt_D, stats_valid}, sample_cnt); end
    #3 rst = 1'b1;
    cyc();
  endtask

  initial begin
    rst = 1'b1; data_in = '0;
    reg_clr = 1'b0; reg_ld = 1'b0; max_clr = 1'b0; max_ld = 1'b0; min_clr = 1'b0; min_ld = 1'b0;
    test_reset();
    test_first_sample();
    test_forwarding();
    test_clear_priority();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
